// File: rtl/volume_key_pulser.sv
// volume_key_pulser: debounced up/down push-buttons to one-cycle pulses; auto-repeat enabled by VOLUME_KEY_AUTO_REPEAT_EN
module volume_key_pulser #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic up,
  output logic down,
  output logic held
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
`ifdef VOLUME_KEY_AUTO_REPEAT_EN
  localparam logic [1:0] REPEAT = 2'd2;
  localparam int TMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_DELAY = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] T_PERIOD = TW'(REPEAT_PERIOD - 1);
  logic [TW-1:0] timer;
`endif
  logic [1:0] raw, meta, sync, db;
  logic [CW-1:0] cnt [2];
  logic [1:0] state;
  logic lat_up, key_up, key_dn, lost;
  assign raw = {btn_up, btn_down};
  assign key_up = db[1] & ~db[0];
  assign key_dn = db[0] & ~db[1];
  assign lost = lat_up ? ~key_up : ~key_dn;
  // two-flop synchroniser per button
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end
  // accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync[i] == db[i]) cnt[i] <= '0;
        else if (cnt[i] == CNT_LAST) begin
          db[i] <= sync[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
`ifndef VOLUME_KEY_AUTO_REPEAT_EN
  assign held = 1'b0;
`endif
  // press-to-pulse FSM; a key change while holding returns to IDLE without a pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      lat_up <= 1'b0;
      up <= 1'b0;
      down <= 1'b0;
`ifdef VOLUME_KEY_AUTO_REPEAT_EN
      held <= 1'b0;
      timer <= '0;
`endif
    end else begin
      up <= 1'b0;
      down <= 1'b0;
      if (state == IDLE) begin
        if (key_up | key_dn) begin
          up <= key_up;
          down <= key_dn;
          lat_up <= key_up;
          state <= HOLD;
`ifdef VOLUME_KEY_AUTO_REPEAT_EN
          timer <= T_DELAY;
`endif
        end
      end else if (lost) begin
        state <= IDLE;
`ifdef VOLUME_KEY_AUTO_REPEAT_EN
        held <= 1'b0;
      end else if (timer == '0) begin
        up <= lat_up;
        down <= ~lat_up;
        held <= 1'b1;
        timer <= T_PERIOD;
        state <= REPEAT;
      end else begin
        timer <= timer - 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_volume_key_pulser.sv
// tb_volume_key_pulser: scoreboard bench with a cycle-level behavioural model of the key pulser
module tb_volume_key_pulser;
  localparam int D = 4;
  localparam int RD = 20;
  localparam int RP = 5;
`ifdef VOLUME_KEY_AUTO_REPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif
  typedef struct {
    string name;
    int act;
    int want;
  } dchk_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic up, down, held;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [2:0] exp_q[$];
  dchk_t dq[$];
  int up_t[$], dn_t[$], held_t[$];
  bit hu[$], hd[$];
  bit mu, md, pulse;
  int k, cur, first, el;
  logic [2:0] e;
  dchk_t d;

  volume_key_pulser #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .up(up),
    .down(down),
    .held(held)
  );

  always #5 clk = ~clk;

  // a level is accepted once the D most recent synchronised samples all disagree with it
  function automatic bit settle(input bit h[$], input bit level);
    for (int i = 0; i < D; i++) if (h[i] == level) return level;
    return !level;
  endfunction

  function automatic int cnt_after(input int q[$], input int t0);
    int n = 0;
    foreach (q[i]) if (q[i] > t0) n++;
    return n;
  endfunction

  function automatic int first_after(input int q[$], input int t0);
    foreach (q[i]) if (q[i] > t0) return q[i];
    return -1;
  endfunction

  // reference model: a key run starting at edge n pulses at its start (or one edge later when it
  // replaces another key), then RD edges later, then every RP edges while the key is unchanged
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hu.delete();
      hd.delete();
      for (int i = 0; i < D + 2; i++) begin
        hu.push_back(1'b0);
        hd.push_back(1'b0);
      end
      mu = 1'b0;
      md = 1'b0;
      cur = 0;
      first = 0;
    end else begin
      cyc++;
      k = (mu && !md) ? 1 : (md && !mu) ? 2 : 0;
      hu.push_back(btn_up);
      hd.push_back(btn_down);
      void'(hu.pop_front());
      void'(hd.pop_front());
      mu = settle(hu, mu);
      md = settle(hd, md);
      if (k != cur) begin
        first = cyc + (cur != 0 ? 1 : 0);
        cur = k;
      end
      el = cyc - first;
      pulse = k != 0 && el >= 0 && (el == 0 || (RPT && el >= RD && (el - RD) % RP == 0));
      exp_q.push_back({pulse && k == 1, pulse && k == 2, RPT && k != 0 && el >= RD});
    end
  end

  // monitor: sole owner of the counters; compares DUT outputs and directed requests
  always @(negedge clk) begin
    while (dq.size() > 0) begin
      d = dq.pop_front();
      checks++;
      if (d.act != d.want) begin
        errors++;
        $display("FAIL %s actual=%0d expected=%0d", d.name, d.act, d.want);
      end
    end
    if (reset) exp_q.delete();
    else begin
      checks++;
      if (up && down) begin
        errors++;
        $display("FAIL excl cyc=%0d up=%b down=%b", cyc, up, down);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({up, down, held} !== e) begin
          errors++;
          $display("FAIL sb cyc=%0d actual up/down/held=%b expected=%b", cyc, {up, down, held}, e);
        end
      end
      if (up) up_t.push_back(cyc);
      if (down) dn_t.push_back(cyc);
      if (held) held_t.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int want);
    dq.push_back('{name, act, want});
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    #1;
    chk("rst_up", int'(up), 0);
    chk("rst_down", int'(down), 0);
    chk("rst_held", int'(held), 0);
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    int t0, t1;
    tick(3);
    reset = 1'b0;
    tick(5);
    btn_up = 1'b1;
    tick(30);
    do_reset();
    t0 = cyc;
    tick(12);
    chk("reset_rearm_first_up", first_after(up_t, t0), t0 + 7);
    btn_up = 1'b0;
    tick(15);
    t0 = cyc;
    btn_up = 1'b1;
    tick(10);
    btn_up = 1'b0;
    tick(20);
    chk("clean_first_up", first_after(up_t, t0), t0 + 7);
    chk("clean_up_count", cnt_after(up_t, t0), 1);
    chk("clean_down_count", cnt_after(dn_t, t0), 0);
    t0 = cyc;
    for (int i = 0; i < 12; i++) begin
      btn_down = (i % 2 == 0);
      tick(1);
    end
    btn_down = 1'b0;
    tick(10);
    chk("bounce_down_count", cnt_after(dn_t, t0), 0);
    chk("bounce_up_count", cnt_after(up_t, t0), 0);
    t1 = cyc;
    btn_down = 1'b1;
    tick(6);
    btn_down = 1'b0;
    tick(15);
    chk("bounce_then_hold_down", cnt_after(dn_t, t1), 1);
    t0 = cyc;
    btn_up = 1'b1;
    btn_down = 1'b1;
    tick(50);
    chk("both_pulses", cnt_after(up_t, t0) + cnt_after(dn_t, t0), 0);
    chk("both_held", cnt_after(held_t, t0), 0);
    t1 = cyc;
    btn_down = 1'b0;
    tick(12);
    chk("both_drop_first_up", first_after(up_t, t1), t1 + 7);
    btn_up = 1'b0;
    tick(15);
    t0 = cyc;
    btn_up = 1'b1;
    tick(60);
    btn_up = 1'b0;
    tick(20);
    chk("repeat_up_count", cnt_after(up_t, t0), RPT ? 9 : 1);
    chk("repeat_second_up", first_after(up_t, t0 + 7), RPT ? t0 + 27 : -1);
    chk("repeat_held_cycles", cnt_after(held_t, t0), RPT ? 40 : 0);
    chk("repeat_held_rise", first_after(held_t, t0), RPT ? t0 + 27 : -1);
    t0 = cyc;
    btn_up = 1'b1;
    tick(40);
    t1 = cyc;
    btn_up = 1'b0;
    btn_down = 1'b1;
    tick(15);
    btn_down = 1'b0;
    tick(15);
    chk("swap_up_count", cnt_after(up_t, t0), RPT ? 5 : 1);
    chk("swap_first_down", first_after(dn_t, t1), t1 + 8);
    chk("swap_down_count", cnt_after(dn_t, t1), 1);
    for (int s = 0; s < 40; s++) begin
      int len;
      bit tu, td;
      len = $urandom_range(2, 70);
      tu = 1'($urandom_range(0, 1));
      td = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) do_reset();
      for (int c = 0; c < len; c++) begin
        if (c < 6 && $urandom_range(0, 1) == 1) begin
          btn_up = 1'($urandom_range(0, 1));
          btn_down = 1'($urandom_range(0, 1));
        end else begin
          btn_up = tu;
          btn_down = td;
        end
        tick(1);
      end
    end
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick(20);
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
